// File: rtl/midi_voice_ctrl_pkg.sv
// Shared types and constants for the MIDI voice controller.
package midi_pkg;

    typedef logic [7:0] midi_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        DATA1,
        DATA2,
        CONVERT
    } parse_state_t;

    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    // Increments for notes 120..131 (1 MHz clock, 24-bit accumulator);
    // lower octaves are obtained by right-shifting these.
    function automatic logic [18:0] note_table(input logic [3:0] idx);
        logic [18:0] val;
        case (idx)
            4'd0:    val = 19'd140459;
            4'd1:    val = 19'd148811;
            4'd2:    val = 19'd157660;
            4'd3:    val = 19'd167035;
            4'd4:    val = 19'd176967;
            4'd5:    val = 19'd187490;
            4'd6:    val = 19'd198639;
            4'd7:    val = 19'd210451;
            4'd8:    val = 19'd222965;
            4'd9:    val = 19'd236223;
            4'd10:   val = 19'd250270;
            4'd11:   val = 19'd265152;
            default: val = 19'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/midi_voice_ctrl_if.sv
// Byte-stream valid/ready link from the UART receiver to the controller.
interface midi_voice_ctrl_if;
    import midi_pkg::*;

    logic       in_valid;
    midi_byte_t in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/midi_voice_ctrl_note_to_freq.sv
// Note number to phase increment: iterative divide-by-12, table lookup,
// octave shift and saturation. i_start loads the note; o_done is high
// for the single cycle in which o_freq is valid.
module note_to_freq
    import midi_pkg::*;
#(
    parameter int FREQ_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [6:0]           i_note,
    output logic                 o_done,
    output logic [FREQ_BITS-1:0] o_freq
);

    logic        r_busy;
    logic [6:0]  r_rem;
    logic [3:0]  r_oct;
    logic [3:0]  w_shift_amt;
    logic [18:0] w_base;
    logic [18:0] w_shifted;

    // Repeated subtraction: remainder ends as the semitone, count as the octave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_rem  <= 7'd0;
            r_oct  <= 4'd0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_rem  <= i_note;
            r_oct  <= 4'd0;
        end else if (r_busy) begin
            if (r_rem >= 7'd12) begin
                r_rem <= r_rem - 7'd12;
                r_oct <= r_oct + 4'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done      = r_busy && (r_rem < 7'd12);
    assign w_base      = note_table(r_rem[3:0]);
    // Table holds octave 10, so shift down by the missing octaves.
    assign w_shift_amt = 4'd10 - r_oct;
    assign w_shifted   = w_base >> w_shift_amt;

    generate
        if (FREQ_BITS >= 19) begin : g_no_sat
            assign o_freq = FREQ_BITS'(w_shifted);
        end else begin : g_sat
            assign o_freq = (|w_shifted[18:FREQ_BITS]) ? '1 : w_shifted[FREQ_BITS-1:0];
        end
    endgenerate

endmodule

// File: rtl/midi_voice_ctrl.sv
// Monophonic MIDI Note On/Off parser for one channel, driving a voice's
// tone increment and envelope gate with last-note priority.
module midi_voice_ctrl
    import midi_pkg::*;
#(
    parameter int         FREQ_BITS = 16,
    parameter logic [3:0] CHANNEL   = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    midi_voice_ctrl_if.slave     bus,
    output logic [FREQ_BITS-1:0] tone_freq,
    output logic                 gate,
    output logic [6:0]           note
);

    parse_state_t         r_state;
    parse_state_t         w_next_state;
    logic                 w_in_ready;
    logic                 w_start;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_is_status;
    logic                 w_is_realtime;
    logic                 w_is_ours;
    logic                 w_velocity_nz;
    logic [FREQ_BITS-1:0] w_freq;

    // "No running status" is represented by sitting in SKIP, so only the
    // On/Off flavour of a valid running status needs storing.
    logic                 r_run_on;
    logic [6:0]           r_pend_note;
    logic [FREQ_BITS-1:0] r_tone_freq;
    logic                 r_gate;
    logic [6:0]           r_note;

    assign w_accept      = bus.in_valid && (r_state != CONVERT);
    assign w_is_status   = bus.in_data[7];
    assign w_is_realtime = (bus.in_data >= REALTIME_MIN);
    assign w_is_ours     = ((bus.in_data[7:4] == NOTE_ON) || (bus.in_data[7:4] == NOTE_OFF))
                           && (bus.in_data[3:0] == CHANNEL);
    assign w_velocity_nz = (bus.in_data[6:0] != 7'd0);

    // Parse state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, ready and conversion start.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = (r_state != CONVERT);
        w_start      = 1'b0;
        if (r_state == CONVERT) begin
            if (w_done) begin
                w_next_state = DATA1;
            end
        end else if (w_accept && !w_is_realtime) begin
            if (w_is_status) begin
                w_next_state = w_is_ours ? DATA1 : SKIP;
            end else begin
                case (r_state)
                    DATA1: w_next_state = DATA2;
                    DATA2: begin
                        if (r_run_on && w_velocity_nz) begin
                            w_next_state = CONVERT;
                            w_start      = 1'b1;
                        end else begin
                            w_next_state = DATA1;
                        end
                    end
                    default: w_next_state = r_state;
                endcase
            end
        end
    end

    // Running status, pending note and voice outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_on    <= 1'b0;
            r_pend_note <= 7'd0;
            r_tone_freq <= '0;
            r_gate      <= 1'b0;
            r_note      <= 7'd0;
        end else begin
            if (w_accept && !w_is_realtime) begin
                if (w_is_status) begin
                    r_run_on <= w_is_ours && (bus.in_data[7:4] == NOTE_ON);
                end else if (r_state == DATA1) begin
                    r_pend_note <= bus.in_data[6:0];
                end else if (r_state == DATA2) begin
                    // New note retriggers via a gate drop; note-off only
                    // releases if it names the sounding note.
                    if (w_start || (r_pend_note == r_note)) begin
                        r_gate <= 1'b0;
                    end
                end
            end
            if ((r_state == CONVERT) && w_done) begin
                r_tone_freq <= w_freq;
                r_note      <= r_pend_note;
                r_gate      <= 1'b1;
            end
        end
    end

    note_to_freq #(
        .FREQ_BITS (FREQ_BITS)
    ) u_note_to_freq (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_note  (r_pend_note),
        .o_done  (w_done),
        .o_freq  (w_freq)
    );

    assign bus.in_ready = w_in_ready;
    assign tone_freq    = r_tone_freq;
    assign gate         = r_gate;
    assign note         = r_note;

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Self-checking bench for midi_voice_ctrl: directed scenarios followed by
// random byte streams, compared against a message-level reference model.
module tb_midi_voice_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] tone_freq;
    logic        gate;
    logic [6:0]  note;

    midi_voice_ctrl_if bus ();

    midi_voice_ctrl #(
        .FREQ_BITS (16),
        .CHANNEL   (4'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .tone_freq (tone_freq),
        .gate      (gate),
        .note      (note)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned note_inc [12] = '{140459, 148811, 157660, 167035, 176967, 187490,
                                   198639, 210451, 222965, 236223, 250270, 265152};

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] last_byte = 8'h00;

    // Reference model: message-level view of the stream.
    int         m_run   = 0;   // 0 none, 1 note on, 2 note off
    int         m_cnt   = 0;   // data bytes collected in current message
    int         m_pend  = 0;
    longint     m_tone  = 0;
    int         m_note  = 0;
    int         m_gate  = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (last byte %02h)", tag, got, exp, last_byte);
        end
    endtask

    function automatic longint exp_freq(input int n);
        longint v;
        v = (longint'(note_inc[n % 12]) << (n / 12)) >> 10;
        if (v > 65535) v = 65535;
        return v;
    endfunction

    task automatic check_outputs();
        check_val("ready", longint'(bus.in_ready), 1);
        check_val("tone",  longint'(tone_freq), m_tone);
        check_val("note",  longint'(note), longint'(m_note));
        check_val("gate",  longint'(gate), longint'(m_gate));
    endtask

    // Present one byte and hold it until accepted; returns #1 after the accepting edge.
    task automatic put_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        last_byte    = b;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 64; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        if (!ok) check_val("accept_timeout", 0, 1);
    endtask

    // Send a byte, advance the model, and check timing and outputs.
    task automatic apply(input logic [7:0] b);
        bit conv;
        int lat;
        conv = 1'b0;
        put_byte(b);
        if (b >= 8'hF8) begin
            // real-time: no effect
        end else if (b[7]) begin
            m_cnt = 0;
            if (b == 8'h90)      m_run = 1;
            else if (b == 8'h80) m_run = 2;
            else                 m_run = 0;
        end else if (m_run != 0) begin
            if (m_cnt == 0) begin
                m_pend = int'(b);
                m_cnt  = 1;
            end else begin
                m_cnt = 0;
                if (m_run == 1 && b != 8'h00) begin
                    conv = 1'b1;
                end else if (m_pend == m_note) begin
                    m_gate = 0;
                end
            end
        end

        if (conv) begin
            lat = m_pend / 12 + 1;
            check_val("conv_ready", longint'(bus.in_ready), 0);
            check_val("conv_gate",  longint'(gate), 0);
            for (int i = 1; i < lat; i++) begin
                @(posedge clk);
                #1;
                check_val("conv_ready", longint'(bus.in_ready), 0);
                check_val("conv_gate",  longint'(gate), 0);
            end
            @(posedge clk);
            #1;
            m_tone = exp_freq(m_pend);
            m_note = m_pend;
            m_gate = 1;
        end
        check_outputs();
    endtask

    task automatic apply_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        apply(a);
        apply(b);
        apply(c);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        logic [7:0] odd_status [5] = '{8'h91, 8'h8F, 8'hB0, 8'hF0, 8'hC0};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed scenarios
        apply_seq(8'h90, 8'h45, 8'h64);          // note 69 -> 7381
        check_val("tone_69", longint'(tone_freq), 7381);
        apply(8'h3C); apply(8'h40);              // running status, note 60 -> 4389
        check_val("tone_60", longint'(tone_freq), 4389);
        apply_seq(8'h80, 8'h45, 8'h00);          // off for a different note
        apply_seq(8'h90, 8'h3C, 8'h00);          // vel 0 releases 60
        check_val("released_gate", longint'(gate), 0);
        apply_seq(8'h91, 8'h45, 8'h64);          // other channel
        apply(8'h40);                            // bare data after foreign status
        apply(8'h90); apply(8'hF8); apply(8'h45); apply(8'h64);
        apply_seq(8'h90, 8'h7F, 8'h64);          // saturating note
        check_val("tone_127", longint'(tone_freq), 65535);
        apply_seq(8'h90, 8'h00, 8'h64);          // lowest note
        check_val("tone_0", longint'(tone_freq), 137);

        // Reset during the third cycle of a conversion
        apply(8'h90); apply(8'h3C);
        put_byte(8'h64);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        m_run = 0; m_cnt = 0; m_tone = 0; m_note = 0; m_gate = 0;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(8'h40);

        // Random stream
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12)      b = 8'h90;
            else if (r < 18) b = 8'h80;
            else if (r < 22) b = odd_status[$urandom_range(0, 4)];
            else if (r < 27) b = 8'hF8 + 8'($urandom_range(0, 7));
            else if (r < 35) b = 8'h00;
            else             b = 8'($urandom_range(0, 127));
            apply(b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/midi_voice_ctrl.md
# midi_voice_ctrl

Monophonic MIDI note controller that drives one `voice`. It consumes a byte stream from a UART receiver over a valid/ready handshake and parses Note On and Note Off messages for one configured channel. It converts the note number to a phase-accumulator increment and drives the voice's `tone_freq` and envelope `gate` inputs.

## Interface
Parameters:
- `FREQ_BITS`, 16: width of `tone_freq`; must match the voice.
- `CHANNEL`, 4'd0: MIDI channel (0–15) this controller responds to.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_data` holds a MIDI byte.
- `in_data`  in  8: MIDI byte.
- `in_ready`  out  1: controller accepts a byte this cycle; a byte transfers when `in_valid && in_ready`.
- `tone_freq`  out  FREQ_BITS: accumulator increment for the voice.
- `gate`  out  1: envelope gate for the voice.
- `note`  out  7: currently sounding note number.

## Operation
- Reset values: `tone_freq`=0, `gate`=0, `note`=0, `in_ready`=1. Running status is cleared to "none" and the state is IDLE.
- Real-time bytes (0xF8–0xFF) are accepted and ignored in every parse state. They leave the state and running status untouched.
- Other status bytes (bit 7 = 1) are accepted in any parse state and restart parsing:
  - 0x9n or 0x8n with n = `CHANNEL`: running status := that byte, go to DATA1.
  - Any other status byte: running status := none, go to SKIP.
- Data bytes (bit 7 = 0):
  - IDLE or SKIP: discarded. SKIP stays in SKIP.
  - DATA1: latch the byte as `pend_note`, go to DATA2.
  - DATA2: the byte is the velocity; then dispatch:
    - Note On with velocity ≠ 0: go to CONVERT.
    - Note Off, or Note On with velocity 0: if `pend_note` == `note`, `gate` <= 0; `tone_freq` and `note` are held. Go to DATA1 (running status).
- CONVERT state:
  - `in_ready` = 0.
  - Entry: `r` := `pend_note`, `o` := 0, `gate` <= 0. The gate drop gives the envelope a retrigger edge.
  - Each cycle with `r` ≥ 12: `r` -= 12, `o` += 1.
  - Cycle with `r` < 12: `tone_freq` <= sat(NOTE_TABLE[r] >> (10 − o)), `note` <= `pend_note`, `gate` <= 1, go to DATA1.
- sat(): if the shifted value is ≥ 2^FREQ_BITS, output all ones; otherwise output the low FREQ_BITS bits.
- Voice allocation is last-note priority: a new Note On always replaces the current note. A Note Off for any other note has no effect.

## Timing
- `in_ready` = 1 in IDLE, SKIP, DATA1 and DATA2, and 0 in CONVERT.
- A velocity byte accepted at edge T puts the controller in CONVERT from T+1.
  - CONVERT lasts floor(note/12)+1 cycles.
  - New `tone_freq`, `note` and `gate`=1 are visible after edge T+floor(note/12)+2.
  - `gate` is 0 from T+1 until that edge.
- A Note Off takes effect at the edge after the velocity byte is accepted.
- All outputs are registered; there are no combinational paths from input to output other than `in_ready`, which decodes from state.
- Asserting `rst` during CONVERT aborts the conversion; all outputs take their reset values immediately.

## Structure
- Package `midi_pkg` holds:
  - Parse state enum: IDLE, SKIP, DATA1, DATA2, CONVERT.
  - Status constants NOTE_ON=4'h9, NOTE_OFF=4'h8, REALTIME_MIN=8'hF8.
  - NOTE_TABLE[0..11], 19-bit increments for MIDI notes 120–131 at 1 MHz with a 24-bit accumulator: 140459, 148811, 157660, 167035, 176967, 187490, 198639, 210451, 222965, 236223, 250270, 265152.
- Sub-module `note_to_freq` contains the CONVERT datapath: iterative divide-by-12, table lookup, shift and saturate. It has a start/done handshake.

## Test plan
- Send 0x90 0x45 0x64 → after velocity edge T: `in_ready`=0 for 6 cycles, then `tone_freq`=7381, `note`=69, `gate`=1 at T+7.
- Running status: 0x3C 0x40 → `gate` drops for 6 cycles, then `tone_freq`=4389, `note`=60, `gate`=1.
- 0x80 0x45 0x00 while note 60 sounds → no change. Then 0x90 0x3C 0x00 → `gate`=0, `tone_freq` stays 4389.
- 0x91 0x45 0x64 with CHANNEL=0 → outputs unchanged. A following bare 0x40 is ignored. 0xF8 inserted between 0x90 and 0x45 does not break the Note On.
- 0x90 0x7F 0x64 → `tone_freq`=65535 (saturated), `note`=127. Note 0 → `tone_freq` = 140459>>10 = 137.
- Assert `rst` on the third cycle of CONVERT → `tone_freq`=0, `gate`=0, `in_ready`=1. A bare data byte after reset is ignored.
